// File: rtl/seg7_pkg.sv
// Shared types and segment tables for seven-segment readback monitors.
// Segment bit order is bit0=a .. bit6=g, active-high.
package seg7_pkg;

    typedef enum logic [2:0] {
        K_BLANK      = 3'd0,
        K_DIGIT      = 3'd1,
        K_SPIN       = 3'd2,
        K_ERR_OVER   = 3'd3,
        K_ERR_CHANGE = 3'd4,
        K_UNKNOWN    = 3'd5
    } seg_kind_t;

    localparam logic [0:9][6:0] SEG_DIGIT = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_ERR_OVER   = 7'h77;
    localparam logic [6:0] SEG_ERR_CHANGE = 7'h03;
    localparam int         SPIN_POSITIONS = 7;

    // Next position in the spinner animation; the last frame wraps to 0.
    function automatic logic [3:0] next_spin_pos(input logic [3:0] pos);
        if (pos == 4'(SPIN_POSITIONS - 1)) begin
            return 4'd0;
        end
        return pos + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_classify.sv
// Combinational segment pattern classifier: pattern -> {kind, value}.
// Overlaps resolve in priority order digit, error, spinner, unknown.
module seg7_classify
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_kind_t  kind,
    output logic [3:0] value
);

    logic [9:0] digit_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_digit
            assign digit_hit[gi] = (pattern == SEG_DIGIT[gi]);
        end
    endgenerate

    // Lowest priority first; each later match overrides the earlier one.
    always_comb begin
        kind  = K_UNKNOWN;
        value = 4'd0;
        for (int i = 0; i < SPIN_POSITIONS; i++) begin
            if (pattern == 7'(1 << i)) begin
                kind  = K_SPIN;
                value = 4'(i);
            end
        end
        if (pattern == SEG_ERR_CHANGE) begin
            kind  = K_ERR_CHANGE;
            value = 4'd0;
        end
        if (pattern == SEG_ERR_OVER) begin
            kind  = K_ERR_OVER;
            value = 4'd0;
        end
        for (int i = 9; i >= 0; i--) begin
            if (digit_hit[i]) begin
                kind  = K_DIGIT;
                value = 4'(i);
            end
        end
        if (pattern == 7'h00) begin
            kind  = K_BLANK;
            value = 4'd0;
        end
    end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Display self-test monitor: debounces one digit's segment bus, decodes settled
// patterns, checks spinner ordering and counts glitches and faults.
module seg7_readback_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [6:0]       seg_in,
    output logic             valid,
    output seg_kind_t        kind,
    output logic [3:0]       value,
    output logic             new_pulse,
    output logic             spin_fault,
    output logic [CNT_W-1:0] glitch_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    localparam int STAB_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LOCKED} state_t;

    state_t            state_reg, state_next;
    logic [6:0]        cand_reg, cand_next;
    logic [STAB_W-1:0] stab_reg, stab_next;
    logic              valid_reg, valid_next;
    seg_kind_t         kind_reg;
    logic [3:0]        value_reg;
    logic              new_pulse_reg, spin_fault_reg;
    logic [CNT_W-1:0]  glitch_cnt_reg, fault_cnt_reg;
    logic              last_spin_vld_reg;
    logic [3:0]        last_pos_reg;

    logic              lock, glitch, spin_fault_next, fault_evt;
    seg_kind_t         cls_kind;
    logic [3:0]        cls_value;

    // Classify the candidate as it will be after this edge; on a lock it equals seg_in.
    seg7_classify u_classify (
        .pattern (cand_next),
        .kind    (cls_kind),
        .value   (cls_value)
    );

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        stab_next  = stab_reg;
        valid_next = valid_reg;
        lock       = 1'b0;
        glitch     = 1'b0;
        if (sample_en) begin
            case (state_reg)
                S_IDLE: begin
                    cand_next = seg_in;
                    stab_next = STAB_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        lock       = 1'b1;
                        state_next = S_LOCKED;
                    end else begin
                        state_next = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (seg_in == cand_reg) begin
                        stab_next = stab_reg + STAB_W'(1);
                        if (stab_reg == STAB_LAST) begin
                            lock       = 1'b1;
                            state_next = S_LOCKED;
                        end
                    end else begin
                        glitch    = 1'b1;
                        cand_next = seg_in;
                        stab_next = STAB_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (seg_in != cand_reg) begin
                        cand_next  = seg_in;
                        stab_next  = STAB_W'(1);
                        valid_next = 1'b0;
                        if (STABLE_CYCLES == 1) begin
                            lock = 1'b1;
                        end else begin
                            state_next = S_SETTLE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
        if (lock) begin
            valid_next = 1'b1;
        end
    end

    assign spin_fault_next = lock && (cls_kind == K_SPIN) && last_spin_vld_reg &&
                             (cls_value != next_spin_pos(last_pos_reg));
    assign fault_evt       = spin_fault_next || (lock && (cls_kind == K_UNKNOWN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            cand_reg          <= '0;
            stab_reg          <= '0;
            valid_reg         <= 1'b0;
            kind_reg          <= K_BLANK;
            value_reg         <= '0;
            new_pulse_reg     <= 1'b0;
            spin_fault_reg    <= 1'b0;
            glitch_cnt_reg    <= '0;
            fault_cnt_reg     <= '0;
            last_spin_vld_reg <= 1'b0;
            last_pos_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            cand_reg       <= cand_next;
            stab_reg       <= stab_next;
            valid_reg      <= valid_next;
            new_pulse_reg  <= lock;
            spin_fault_reg <= spin_fault_next;
            if (lock) begin
                kind_reg          <= cls_kind;
                value_reg         <= cls_value;
                last_spin_vld_reg <= (cls_kind == K_SPIN);
                if (cls_kind == K_SPIN) begin
                    last_pos_reg <= cls_value;
                end
            end
            if (glitch && (glitch_cnt_reg != '1)) begin
                glitch_cnt_reg <= glitch_cnt_reg + CNT_W'(1);
            end
            if (fault_evt && (fault_cnt_reg != '1)) begin
                fault_cnt_reg <= fault_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign valid      = valid_reg;
    assign kind       = kind_reg;
    assign value      = value_reg;
    assign new_pulse  = new_pulse_reg;
    assign spin_fault = spin_fault_reg;
    assign glitch_cnt = glitch_cnt_reg;
    assign fault_cnt  = fault_cnt_reg;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder; expected locks are queued as
// stimulus is driven and popped whenever the DUT pulses new_pulse.
module tb_seg7_readback_decoder;
    import seg7_pkg::*;

    logic       clk;
    logic       reset;
    logic       sample_en;
    logic [6:0] seg_in;
    logic       valid;
    seg_kind_t  kind;
    logic [3:0] value;
    logic       new_pulse;
    logic       spin_fault;
    logic [7:0] glitch_cnt;
    logic [7:0] fault_cnt;

    typedef struct {
        seg_kind_t  kind;
        logic [3:0] value;
        logic       fault;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    seg7_readback_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .seg_in     (seg_in),
        .valid      (valid),
        .kind       (kind),
        .value      (value),
        .new_pulse  (new_pulse),
        .spin_fault (spin_fault),
        .glitch_cnt (glitch_cnt),
        .fault_cnt  (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic expect_lock(input seg_kind_t k, input logic [3:0] v, input logic f);
        exp_t e;
        e.kind  = k;
        e.value = v;
        e.fault = f;
        sb.push_back(e);
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (new_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_lock", 32'(new_pulse), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("lock_kind", 32'(kind), 32'(e.kind));
                chk("lock_value", 32'(value), 32'(e.value));
                chk("lock_spin_fault", 32'(spin_fault), 32'(e.fault));
                chk("lock_valid", 32'(valid), 32'd1);
                $display("lock kind=%0d value=%0d spin_fault=%0b", kind, value, spin_fault);
            end
        end else if (spin_fault) begin
            chk("stray_spin_fault", 32'(spin_fault), 32'd0);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        sample_en = 1'b1;
        seg_in    = p;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sample_en = 1'b0;
        cyc();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_kind"}, 32'(kind), 32'd0);
        chk({tag, "_value"}, 32'(value), 32'd0);
        chk({tag, "_new_pulse"}, 32'(new_pulse), 32'd0);
        chk({tag, "_spin_fault"}, 32'(spin_fault), 32'd0);
        chk({tag, "_glitch_cnt"}, 32'(glitch_cnt), 32'd0);
        chk({tag, "_fault_cnt"}, 32'(fault_cnt), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        sample_en = 1'b0;
        seg_in    = 7'h00;
        cyc();
        do_reset();
        chk_all_zero("reset");

        // 1: digit 2 locks on the 4th enabled sample
        hold(7'h5B, 3);
        chk("t1_valid_early", 32'(valid), 32'd0);
        expect_lock(K_DIGIT, 4'd2, 1'b0);
        hold(7'h5B, 1);
        chk("t1_valid", 32'(valid), 32'd1);
        hold(7'h5B, 2);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: short 0x06 is a glitch, 0x4F then locks as 3
        hold(7'h06, 2);
        chk("t2_valid_drop", 32'(valid), 32'd0);
        expect_lock(K_DIGIT, 4'd3, 1'b0);
        hold(7'h4F, 5);
        chk("t2_glitch_cnt", 32'(glitch_cnt), 32'd1);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: full spinner sweep with wrap, no faults
        for (int i = 0; i < 8; i++) begin
            expect_lock(K_SPIN, 4'(i % 7), 1'b0);
            hold(7'(1 << (i % 7)), 4);
        end
        chk("t3_fault_cnt", 32'(fault_cnt), 32'd0);
        chk("t3_glitch_cnt", 32'(glitch_cnt), 32'd1);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // 4: out-of-order spinner step
        do_reset();
        expect_lock(K_SPIN, 4'd2, 1'b0);
        hold(7'h04, 4);
        expect_lock(K_SPIN, 4'd5, 1'b1);
        hold(7'h20, 4);
        chk("t4_fault_cnt", 32'(fault_cnt), 32'd1);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: error patterns, unknown pattern, spinner after error
        expect_lock(K_ERR_OVER, 4'd0, 1'b0);
        hold(7'h77, 4);
        expect_lock(K_ERR_CHANGE, 4'd0, 1'b0);
        hold(7'h03, 4);
        expect_lock(K_UNKNOWN, 4'd0, 1'b0);
        hold(7'h55, 4);
        chk("t5_fault_cnt_unknown", 32'(fault_cnt), 32'd2);
        expect_lock(K_SPIN, 4'd2, 1'b0);
        hold(7'h04, 4);
        chk("t5_fault_cnt", 32'(fault_cnt), 32'd2);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // 6a: sample_en=0 freezes the filter mid-settle
        do_reset();
        hold(7'h6D, 2);
        sample_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seg_in = 7'($urandom_range(0, 127));
            cyc();
        end
        hold(7'h6D, 1);
        chk("t6a_valid_early", 32'(valid), 32'd0);
        chk("t6a_glitch_cnt", 32'(glitch_cnt), 32'd0);
        expect_lock(K_DIGIT, 4'd5, 1'b0);
        hold(7'h6D, 1);
        chk("t6a_valid", 32'(valid), 32'd1);
        chk("t6a_sb_empty", 32'(sb.size()), 32'd0);

        // 6b: reset mid-settle clears everything
        hold(7'h7F, 2);
        do_reset();
        chk_all_zero("t6b");

        // 6c: glitch counter saturates
        for (int i = 0; i <= 300; i++) begin
            hold((i % 2 == 1) ? 7'h02 : 7'h01, 1);
            if (i == 100) chk("t6c_glitch_100", 32'(glitch_cnt), 32'd100);
        end
        chk("t6c_glitch_sat", 32'(glitch_cnt), 32'hFF);
        chk("t6c_valid", 32'(valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
